// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory: FSM states,
// read response bundle and strobe-width helper.
package dmem_pkg;

    localparam int MAX_DATA_W = 64;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } dmem_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [MAX_DATA_W-1:0] data;
    } dmem_rsp_t;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// In-order read response pipeline, RD_LAT stages deep.
// Stage 0 is loaded at the accept edge; the last stage feeds the port.
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  dmem_rsp_t ld,
    output dmem_rsp_t q
);

    dmem_rsp_t stg [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= ld;
            for (int i = 1; i < RD_LAT; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[RD_LAT-1];

endmodule

// File: rtl/dmem_pipe_ctrl.sv
// Single-port MEM-stage data memory: valid/ready requests, byte
// strobes, pipelined reads, post-reset clear sweep, range check.
module dmem_pipe_ctrl
    import dmem_pkg::*;
#(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 1 << ADDR_W,
    parameter int                RD_LAT     = 2,
    parameter int                CLR_ON_RST = 1,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [strb_w(DATA_W)-1:0]   req_wstrb,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        busy
);

    localparam int SW = strb_w(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    dmem_state_e       state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_nxt;
    logic              sweep_we;
    logic              accept;
    logic              in_range;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;
    dmem_rsp_t         ld, q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLR_ON_RST != 0) ? ST_INIT : ST_READY;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_cnt;
        sweep_we  = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_INIT: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                clr_nxt  = clr_cnt + 1'b1;
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                req_ready = 1'b1;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
        // Reset cycle reports the post-reset view regardless of old state
        if (rst) begin
            req_ready = 1'b0;
            sweep_we  = 1'b0;
            busy      = (CLR_ON_RST != 0);
        end
    end

    assign accept   = req_valid && req_ready;
    assign in_range = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
    assign wr_en    = accept && req_we && in_range;
    assign rd_word  = in_range ? mem[req_addr] : '0;

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[clr_cnt] <= INIT_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < SW; i++) begin
                if (req_wstrb[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ld = '0;
        if (accept && !req_we) begin
            ld.valid = 1'b1;
            ld.err   = !in_range;
            ld.data  = MAX_DATA_W'(rd_word);
        end
    end

    dmem_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .q   (q)
    );

    assign rsp_valid = q.valid;
    assign rsp_err   = q.valid && q.err;
    assign rsp_rdata = q.valid ? DATA_W'(q.data) : '0;

    task write_word(input logic [ADDR_W-1:0] addr,
                    input logic [DATA_W-1:0] data);
        mem[addr] <= data;
    endtask

    function logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
        return mem[addr];
    endfunction

endmodule

// File: tb/tb_dmem_pipe_ctrl.sv
// Directed bench for dmem_pipe_ctrl: two instances cover clear-on-reset
// with RD_LAT=2 / DEPTH=16 and no-clear with RD_LAT=3 / DEPTH=12.
module tb_dmem_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        a_rst, a_req_valid, a_req_ready, a_req_we;
    logic [3:0]  a_req_addr;
    logic [31:0] a_req_wdata;
    logic [3:0]  a_req_wstrb;
    logic        a_rsp_valid, a_rsp_err, a_busy;
    logic [31:0] a_rsp_rdata;

    logic        b_rst, b_req_valid, b_req_ready, b_req_we;
    logic [3:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic [3:0]  b_req_wstrb;
    logic        b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    dmem_pipe_ctrl #(
        .ADDR_W(4), .DATA_W(32), .DEPTH(16), .RD_LAT(2),
        .CLR_ON_RST(1), .INIT_VAL(32'hDEAD_BEEF)
    ) u_a (
        .clk(clk), .rst(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy)
    );

    dmem_pipe_ctrl #(
        .ADDR_W(4), .DATA_W(32), .DEPTH(12), .RD_LAT(3),
        .CLR_ON_RST(0), .INIT_VAL(32'h0)
    ) u_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        logic rdy_seen;
        a_rst = 1'b1;
        step();
        step();
        checks++;
        if (a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: got %b want 0", a_req_ready);
        end
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy: got %b want 1", a_busy);
        end
        checks++;
        if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_rsp: got v=%b e=%b want 0 0", a_rsp_valid, a_rsp_err);
        end
        checks++;
        if (a_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata: got %h want 0", a_rsp_rdata);
        end
        a_rst = 1'b0;
        n = 0;
        rdy_seen = 1'b0;
        while (a_busy === 1'b1 && n < 100) begin
            if (a_req_ready !== 1'b0) rdy_seen = 1'b1;
            n++;
            step();
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL sweep_len: got %0d cycles want 16", n);
        end
        checks++;
        if (rdy_seen !== 1'b0) begin
            errors++;
            $display("FAIL sweep_ready: got ready=1 during sweep want 0");
        end
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_sweep_ready: got %b want 1", a_req_ready);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (u_a.read_word(4'(i)) !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL sweep_word[%0d]: got %h want deadbeef",
                         i, u_a.read_word(4'(i)));
            end
        end
    endtask

    task automatic test_strobe_merge();
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_addr  = 4'd5;
        a_req_wdata = 32'h1122_3344;
        a_req_wstrb = 4'b1111;
        step();
        a_req_wdata = 32'hAABB_CCDD;
        a_req_wstrb = 4'b0101;
        step();
        a_req_we    = 1'b0;
        a_req_wstrb = 4'b0000;
        step();
        a_req_valid = 1'b0;
        checks++;
        if (a_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL merge_early: got valid=%b want 0", a_rsp_valid);
        end
        step();
        checks++;
        if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL merge_valid: got v=%b e=%b want 1 0", a_rsp_valid, a_rsp_err);
        end
        checks++;
        if (a_rsp_rdata !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL merge_data: got %h want 11bb33dd", a_rsp_rdata);
        end
        step();
        checks++;
        if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL merge_pulse: got v=%b d=%h want 0 0", a_rsp_valid, a_rsp_rdata);
        end
    endtask

    task automatic test_no_clear();
        checks++;
        if (b_req_ready !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL nc_rst: got rdy=%b busy=%b want 0 0", b_req_ready, b_busy);
        end
        b_rst = 1'b0;
        step();
        checks++;
        if (b_req_ready !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL nc_ready: got rdy=%b busy=%b want 1 0", b_req_ready, b_busy);
        end
        u_b.write_word(4'd3, 32'hCAFE_F00D);
        step();
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = 4'd3;
        b_req_wdata = 32'h1234_5678;
        b_req_wstrb = 4'b0000;
        step();
        b_req_valid = 1'b0;
        step();
        checks++;
        if (u_b.read_word(4'd3) !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL nc_strb0: got %h want cafef00d", u_b.read_word(4'd3));
        end
        b_req_valid = 1'b1;
        b_req_wdata = 32'hAA00_0000;
        b_req_wstrb = 4'b1000;
        step();
        b_req_valid = 1'b0;
        step();
        checks++;
        if (u_b.read_word(4'd3) !== 32'hAAFE_F00D) begin
            errors++;
            $display("FAIL nc_lane3: got %h want aafef00d", u_b.read_word(4'd3));
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        logic [31:0] exp_d;
        for (int i = 0; i < 8; i++) u_b.write_word(4'(i), 32'(i * 3));
        step();
        b_req_we    = 1'b0;
        b_req_wstrb = 4'b0000;
        for (int j = 0; j < 12; j++) begin
            b_req_valid = (j < 8);
            b_req_addr  = 4'(j);
            step();
            exp_v = (j >= 2 && j < 10);
            exp_d = exp_v ? 32'((j - 2) * 3) : 32'h0;
            checks++;
            if (b_rsp_valid !== exp_v || b_rsp_rdata !== exp_d || b_rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d]: got v=%b d=%h e=%b want v=%b d=%h e=0",
                         j, b_rsp_valid, b_rsp_rdata, b_rsp_err, exp_v, exp_d);
            end
        end
        b_req_valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 12; i++) u_b.write_word(4'(i), 32'h100 + 32'(i));
        step();
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_wstrb = 4'b1111;
        b_req_wdata = 32'hFFFF_FFFF;
        b_req_addr  = 4'd12;
        step();
        b_req_addr  = 4'd13;
        step();
        b_req_we    = 1'b0;
        step();
        b_req_addr  = 4'd11;
        step();
        b_req_valid = 1'b0;
        checks++;
        if (b_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL oor_early: got valid=%b want 0", b_rsp_valid);
        end
        step();
        checks++;
        if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1 || b_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_rsp: got v=%b e=%b d=%h want 1 1 0",
                     b_rsp_valid, b_rsp_err, b_rsp_rdata);
        end
        step();
        checks++;
        if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0 || b_rsp_rdata !== 32'h10B) begin
            errors++;
            $display("FAIL last_word_rsp: got v=%b e=%b d=%h want 1 0 0000010b",
                     b_rsp_valid, b_rsp_err, b_rsp_rdata);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (u_b.read_word(4'(i)) !== 32'h100 + 32'(i)) begin
                errors++;
                $display("FAIL oor_word[%0d]: got %h want %h",
                         i, u_b.read_word(4'(i)), 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        logic v_seen;
        a_req_valid = 1'b1;
        a_req_we    = 1'b0;
        a_req_wstrb = 4'b0000;
        a_req_addr  = 4'd1;
        step();
        a_req_addr  = 4'd2;
        step();
        a_req_valid = 1'b0;
        a_rst       = 1'b1;
        step();
        a_rst = 1'b0;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst: got v=%b busy=%b want 0 1", a_rsp_valid, a_busy);
        end
        v_seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            if (a_rsp_valid !== 1'b0) v_seen = 1'b1;
        end
        u_a.write_word(4'd0, 32'h0BAD_0000);
        u_a.write_word(4'd6, 32'h0BAD_0006);
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        n = 0;
        while (a_busy === 1'b1 && n < 100) begin
            if (a_rsp_valid !== 1'b0) v_seen = 1'b1;
            n++;
            step();
        end
        checks++;
        if (v_seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_rsp: got rsp_valid=1 after reset want 0");
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL mid_sweep_len: got %0d cycles want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (u_a.read_word(4'(i)) !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL mid_word[%0d]: got %h want deadbeef",
                         i, u_a.read_word(4'(i)));
            end
        end
    endtask

    initial begin
        a_rst = 1'b1;
        a_req_valid = 1'b0;
        a_req_we = 1'b0;
        a_req_addr = '0;
        a_req_wdata = '0;
        a_req_wstrb = '0;
        b_rst = 1'b1;
        b_req_valid = 1'b0;
        b_req_we = 1'b0;
        b_req_addr = '0;
        b_req_wdata = '0;
        b_req_wstrb = '0;
        test_reset();
        test_strobe_merge();
        test_no_clear();
        test_back_to_back();
        test_out_of_range();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
